// File: rtl/udma_ethernet_pkg.sv
// rtl/udma_ethernet_pkg.sv - shared Ethernet CRC-32 constants, RX FSM states and byte-wide CRC step
package udma_ethernet_pkg;

    localparam logic [31:0] ETH_CRC32_POLY = 32'hEDB88320;
    localparam logic [31:0] ETH_CRC32_INIT = 32'hFFFFFFFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        STREAM = 2'd2,
        DROP   = 2'd3
    } rx_state_e;

    // Reflected CRC-32, LSB of the data byte enters first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ ETH_CRC32_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/udma_ethernet_crc32.sv
// rtl/udma_ethernet_crc32.sv - combinational byte-wide Ethernet CRC-32 next state
module udma_ethernet_crc32
    import udma_ethernet_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);

    assign crc_o = crc32_byte(crc_i, data_i);

endmodule

// File: rtl/udma_ethernet_rx_fcs.sv
// rtl/udma_ethernet_rx_fcs.sv - RX FCS check/strip stage; ETH_RX_FCS_STATS_EN adds good/bad frame counters
module udma_ethernet_rx_fcs
    import udma_ethernet_pkg::*;
#(
    parameter int MIN_FRAME = 5
) (
    input  logic        clk_i,
    input  logic        rstn_i,
`ifdef ETH_RX_FCS_STATS_EN
    input  logic        stat_clr_i,
    output logic [15:0] stat_good_o,
    output logic [15:0] stat_bad_o,
`endif
    input  logic        en_i,
    input  logic [7:0]  s_data_i,
    input  logic        s_valid_i,
    input  logic        s_last_i,
    input  logic        s_user_i,
    output logic        s_ready_o,
    output logic [7:0]  m_data_o,
    output logic        m_valid_o,
    output logic        m_last_o,
    output logic        m_user_o,
    input  logic        m_ready_i,
    output logic [31:0] fcs_o,
    output logic        frame_ok_o,
    output logic        bad_fcs_o,
    output logic        bad_frame_o
);

    localparam logic [15:0] MIN_LEN = 16'(MIN_FRAME);

    rx_state_e        state_q, state_d;
    logic [2:0]       fill_q, fill_d;
    logic [3:0][7:0]  byte_q, byte_d;
    logic [31:0]      crc_q, crc_d, crc_upd;
    logic             err_q, err_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [7:0]       m_data_q, m_data_d;
    logic             m_valid_q, m_valid_d, m_last_q, m_last_d, m_user_q, m_user_d;
    logic [31:0]      fcs_q, fcs_d;
    logic             ok_q, ok_d, bfcs_q, bfcs_d, bframe_q, bframe_d;

    logic             s_fire, err_now, fcs_bad;
    logic [15:0]      cnt_inc;
    logic [31:0]      rx_fcs;

    udma_ethernet_crc32 u_crc (
        .crc_i  (crc_q),
        .data_i (byte_q[0]),
        .crc_o  (crc_upd)
    );

    assign s_ready_o = (state_q == DROP) | ~m_valid_q | m_ready_i;
    assign s_fire    = s_valid_i & s_ready_o;
    assign err_now   = err_q | s_user_i;
    assign cnt_inc   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    assign rx_fcs    = {s_data_i, byte_q[3], byte_q[2], byte_q[1]};
    assign fcs_bad   = (~crc_upd) != rx_fcs;

    always_comb begin
        state_d   = state_q;
        fill_d    = fill_q;
        byte_d    = byte_q;
        crc_d     = crc_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q & ~m_ready_i;
        m_last_d  = m_last_q;
        m_user_d  = m_user_q;
        fcs_d     = fcs_q;
        ok_d      = 1'b0;
        bfcs_d    = 1'b0;
        bframe_d  = 1'b0;
        if (s_fire) begin
            case (state_q)
                IDLE: begin
                    if (!en_i) begin
                        state_d = s_last_i ? IDLE : DROP;
                    end else if (s_last_i) begin
                        bframe_d = 1'b1;
                    end else begin
                        byte_d[0] = s_data_i;
                        fill_d    = 3'd1;
                        err_d     = s_user_i;
                        cnt_d     = 16'd1;
                        state_d   = FILL;
                    end
                end
                FILL: begin
                    if (s_last_i) begin
                        bframe_d = 1'b1;
                        fill_d   = 3'd0;
                        err_d    = 1'b0;
                        cnt_d    = 16'd0;
                        state_d  = IDLE;
                    end else begin
                        byte_d[fill_q[1:0]] = s_data_i;
                        fill_d  = fill_q + 3'd1;
                        err_d   = err_now;
                        cnt_d   = cnt_inc;
                        if (fill_q == 3'd3) state_d = STREAM;
                    end
                end
                STREAM: begin
                    // Oldest byte leaves the buffer; the last four bytes held back are the FCS.
                    m_data_d  = byte_q[0];
                    m_valid_d = 1'b1;
                    m_last_d  = s_last_i;
                    m_user_d  = 1'b0;
                    if (s_last_i) begin
                        m_user_d = fcs_bad | err_now;
                        fcs_d    = rx_fcs;
                        if (err_now || cnt_inc < MIN_LEN) bframe_d = 1'b1;
                        else if (fcs_bad)                 bfcs_d   = 1'b1;
                        else                              ok_d     = 1'b1;
                        crc_d   = ETH_CRC32_INIT;
                        fill_d  = 3'd0;
                        err_d   = 1'b0;
                        cnt_d   = 16'd0;
                        state_d = IDLE;
                    end else begin
                        crc_d  = crc_upd;
                        byte_d = {s_data_i, byte_q[3:1]};
                        err_d  = err_now;
                        cnt_d  = cnt_inc;
                    end
                end
                DROP: begin
                    if (s_last_i) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= IDLE;
            fill_q    <= 3'd0;
            byte_q    <= '0;
            crc_q     <= ETH_CRC32_INIT;
            err_q     <= 1'b0;
            cnt_q     <= 16'd0;
            m_data_q  <= 8'd0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_user_q  <= 1'b0;
            fcs_q     <= 32'd0;
            ok_q      <= 1'b0;
            bfcs_q    <= 1'b0;
            bframe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            fill_q    <= fill_d;
            byte_q    <= byte_d;
            crc_q     <= crc_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            m_user_q  <= m_user_d;
            fcs_q     <= fcs_d;
            ok_q      <= ok_d;
            bfcs_q    <= bfcs_d;
            bframe_q  <= bframe_d;
        end
    end

    assign m_data_o    = m_data_q;
    assign m_valid_o   = m_valid_q;
    assign m_last_o    = m_last_q;
    assign m_user_o    = m_user_q;
    assign fcs_o       = fcs_q;
    assign frame_ok_o  = ok_q;
    assign bad_fcs_o   = bfcs_q;
    assign bad_frame_o = bframe_q;

`ifdef ETH_RX_FCS_STATS_EN
    logic [15:0] stat_good_q, stat_bad_q;

    // Counters follow the registered pulses; clear wins over a same-cycle increment.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            stat_good_q <= 16'd0;
            stat_bad_q  <= 16'd0;
        end else if (stat_clr_i) begin
            stat_good_q <= 16'd0;
            stat_bad_q  <= 16'd0;
        end else begin
            if (ok_q && stat_good_q != 16'hFFFF)                stat_good_q <= stat_good_q + 16'd1;
            if ((bfcs_q || bframe_q) && stat_bad_q != 16'hFFFF) stat_bad_q  <= stat_bad_q + 16'd1;
        end
    end

    assign stat_good_o = stat_good_q;
    assign stat_bad_o  = stat_bad_q;
`endif

endmodule

// File: tb/tb_udma_ethernet_rx_fcs.sv
// tb/tb_udma_ethernet_rx_fcs.sv - randomized self-checking bench for udma_ethernet_rx_fcs
module tb_udma_ethernet_rx_fcs;

    typedef logic [7:0] bq_t[$];

    logic        clk_i = 1'b0, rstn_i = 1'b0, en_i = 1'b0;
    logic [7:0]  s_data_i = 8'd0;
    logic        s_valid_i = 1'b0, s_last_i = 1'b0, s_user_i = 1'b0, m_ready_i = 1'b1;
    logic        s_ready_o, m_valid_o, m_last_o, m_user_o, frame_ok_o, bad_fcs_o, bad_frame_o;
    logic [7:0]  m_data_o;
    logic [31:0] fcs_o;
`ifdef ETH_RX_FCS_STATS_EN
    logic        stat_clr_i = 1'b0;
    logic [15:0] stat_good_o, stat_bad_o;
`endif

    int errors = 0, checks = 0, cyc = 0, ready_mode = 0;
    int n_ok, n_bfcs, n_bframe, multi_err, stall_err;
    logic [7:0] q_data[$];
    logic       q_last[$], q_user[$];
    int         out_cyc[$], acc_cyc[$];
    logic       prev_stall = 1'b0, pl, pu;
    logic [7:0] pd;
    logic [31:0] exp_fcs = 32'd0;

    udma_ethernet_rx_fcs #(.MIN_FRAME(5)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
`ifdef ETH_RX_FCS_STATS_EN
        .stat_clr_i(stat_clr_i), .stat_good_o(stat_good_o), .stat_bad_o(stat_bad_o),
`endif
        .en_i(en_i), .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_last_i(s_last_i),
        .s_user_i(s_user_i), .s_ready_o(s_ready_o), .m_data_o(m_data_o), .m_valid_o(m_valid_o),
        .m_last_o(m_last_o), .m_user_o(m_user_o), .m_ready_i(m_ready_i), .fcs_o(fcs_o),
        .frame_ok_o(frame_ok_o), .bad_fcs_o(bad_fcs_o), .bad_frame_o(bad_frame_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    initial begin
        forever begin
            @(posedge clk_i); #1;
            m_ready_i = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
        end
    end

    always @(negedge clk_i) begin
        if (prev_stall && (m_valid_o !== 1'b1 || m_data_o !== pd || m_last_o !== pl || m_user_o !== pu))
            stall_err++;
        prev_stall = m_valid_o && !m_ready_i;
        pd = m_data_o; pl = m_last_o; pu = m_user_o;
        if (m_valid_o === 1'b1 && m_ready_i) begin
            q_data.push_back(m_data_o); q_last.push_back(m_last_o); q_user.push_back(m_user_o);
            out_cyc.push_back(cyc);
        end
        if (frame_ok_o === 1'b1) n_ok++;
        if (bad_fcs_o === 1'b1) n_bfcs++;
        if (bad_frame_o === 1'b1) n_bframe++;
        if ((frame_ok_o + bad_fcs_o + bad_frame_o) > 2'd1) multi_err++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // Reference: bit-serial reflected CRC-32 over the payload bytes, LSB first.
    function automatic logic [31:0] ref_crc(input bq_t p);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFFFFFF;
        foreach (p[i]) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ p[i][b];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB88320;
            end
        end
        return ~c;
    endfunction

    function automatic bq_t with_fcs(input bq_t p, input logic [31:0] f);
        bq_t r;
        r = p;
        for (int i = 0; i < 4; i++) r.push_back(f[8*i +: 8]);
        return r;
    endfunction

    task automatic clear_mon();
        q_data.delete(); q_last.delete(); q_user.delete(); out_cyc.delete(); acc_cyc.delete();
        n_ok = 0; n_bfcs = 0; n_bframe = 0; multi_err = 0; stall_err = 0;
    endtask

    task automatic send_frame(input bq_t f, input int uidx, input logic en0, input logic en1, input int gap);
        int  g;
        logic acc;
        for (int i = 0; i < f.size(); i++) begin
            while (gap > 0 && $urandom_range(0, 99) < gap) begin
                s_valid_i = 1'b0; @(posedge clk_i); #1;
            end
            s_valid_i = 1'b1; s_data_i = f[i]; s_last_i = (i == f.size() - 1);
            s_user_i = (i == uidx); en_i = (i == 0) ? en0 : en1;
            g = 0;
            do begin
                @(negedge clk_i); acc = s_ready_o;
                if (acc) acc_cyc.push_back(cyc + 1);
                @(posedge clk_i); #1; g++;
            end while (!acc && g < 1000);
            if (!acc) begin
                checks++; errors++;
                $display("FAIL send_timeout: byte %0d never accepted", i);
            end
        end
        s_valid_i = 1'b0; s_last_i = 1'b0; s_user_i = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        repeat (3) @(posedge clk_i);
        while (m_valid_o === 1'b1 && g < 1000) begin @(posedge clk_i); g++; end
        if (g >= 1000) begin
            checks++; errors++;
            $display("FAIL drain_timeout: m_valid_o stuck high");
        end
        repeat (3) @(posedge clk_i); #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk_i); #1;
        checks++;
        if ({m_valid_o, m_last_o, m_user_o, frame_ok_o, bad_fcs_o, bad_frame_o} !== 6'b0 || m_data_o !== 8'd0 || fcs_o !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b data=%h fcs=%h pulses=%b%b%b, need all 0", m_valid_o, m_data_o, fcs_o, frame_ok_o, bad_fcs_o, bad_frame_o);
        end
        rstn_i = 1'b1; en_i = 1'b1;
        @(posedge clk_i); #1;
        checks++;
        if (s_ready_o !== 1'b1 || m_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got s_ready=%b m_valid=%b, need 1 0", s_ready_o, m_valid_o);
        end
    endtask

    task automatic test_good_frame(input logic [7:0] last_b, input logic [31:0] want_fcs, input int kind, input string nm);
        bq_t p, f;
        int  bad;
        logic u;
        clear_mon(); ready_mode = 0;
        p = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        f = p; f.push_back(8'h26); f.push_back(8'h39); f.push_back(8'hF4); f.push_back(last_b);
        send_frame(f, -1, 1'b1, 1'b1, 0);
        drain();
        bad = 0;
        foreach (p[i]) if (i >= q_data.size() || q_data[i] !== p[i] || q_last[i] !== (i == p.size() - 1)) bad++;
        checks++;
        if (q_data.size() != p.size() || bad != 0) begin
            errors++; $display("FAIL %s_data: got %0d bytes (%0d wrong), need 9", nm, q_data.size(), bad);
        end
        u = (q_user.size() > 0) ? q_user[q_user.size() - 1] : 1'bx;
        checks++;
        if (u !== (kind != 0)) begin
            errors++; $display("FAIL %s_user: got %b need %b", nm, u, kind != 0);
        end
        checks++;
        if (fcs_o !== want_fcs) begin
            errors++; $display("FAIL %s_fcs: got %h need %h", nm, fcs_o, want_fcs);
        end
        exp_fcs = want_fcs;
        checks++;
        if (n_ok != int'(kind == 0) || n_bfcs != int'(kind == 1) || n_bframe != 0 || multi_err != 0) begin
            errors++; $display("FAIL %s_pulse: got ok=%0d fcs=%0d frame=%0d", nm, n_ok, n_bfcs, n_bframe);
        end
        checks++;
        if (out_cyc.size() != 9 || acc_cyc.size() != 13 || out_cyc[0] != acc_cyc[4] || out_cyc[8] - out_cyc[0] != 8) begin
            errors++; $display("FAIL %s_latency: got %0d outputs, first at cycle %0d, 5th accept at %0d", nm, out_cyc.size(),
                               (out_cyc.size() > 0) ? out_cyc[0] : -1, (acc_cyc.size() > 4) ? acc_cyc[4] : -1);
        end
    endtask

    task automatic test_runt();
        clear_mon(); ready_mode = 0;
        send_frame('{8'hAA, 8'hBB, 8'hCC}, -1, 1'b1, 1'b1, 0);
        drain();
        checks++;
        if (q_data.size() != 0 || n_bframe != 1 || n_ok != 0 || n_bfcs != 0 || fcs_o !== exp_fcs) begin
            errors++; $display("FAIL runt: got %0d bytes out, bad_frame=%0d ok=%0d fcs=%h, need 0 1 0 %h", q_data.size(), n_bframe, n_ok, fcs_o, exp_fcs);
        end
    endtask

    task automatic test_drop();
        bq_t p, f;
        p = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        f = with_fcs(p, ref_crc(p));
        clear_mon(); ready_mode = 0;
        send_frame(f, -1, 1'b0, 1'b1, 0);
        drain();
        checks++;
        if (q_data.size() != 0 || n_ok + n_bfcs + n_bframe != 0 || fcs_o !== exp_fcs) begin
            errors++; $display("FAIL drop: got %0d bytes, %0d pulses, fcs=%h", q_data.size(), n_ok + n_bfcs + n_bframe, fcs_o);
        end
        clear_mon();
        send_frame(f, -1, 1'b1, 1'b1, 0);
        drain();
        checks++;
        if (q_data.size() != 9 || n_ok != 1 || fcs_o !== 32'hCBF43926) begin
            errors++; $display("FAIL drop_next: got %0d bytes ok=%0d fcs=%h, need 9 1 cbf43926", q_data.size(), n_ok, fcs_o);
        end
        exp_fcs = 32'hCBF43926;
    endtask

    task automatic test_user_err();
        bq_t p, f;
        logic u;
        p = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        f = with_fcs(p, ref_crc(p));
        clear_mon(); ready_mode = 0;
`ifdef ETH_RX_FCS_STATS_EN
        stat_clr_i = 1'b1; @(posedge clk_i); #1; stat_clr_i = 1'b0;
`endif
        send_frame(f, 3, 1'b1, 1'b1, 0);
        drain();
        u = (q_user.size() > 0) ? q_user[q_user.size() - 1] : 1'bx;
        checks++;
        if (q_data.size() != 9 || u !== 1'b1) begin
            errors++; $display("FAIL user_err_out: got %0d bytes last user=%b, need 9 1", q_data.size(), u);
        end
        checks++;
        if (n_bframe != 1 || n_bfcs != 0 || n_ok != 0) begin
            errors++; $display("FAIL user_err_pulse: got ok=%0d fcs=%0d frame=%0d, need 0 0 1", n_ok, n_bfcs, n_bframe);
        end
`ifdef ETH_RX_FCS_STATS_EN
        checks++;
        if (stat_bad_o !== 16'd1 || stat_good_o !== 16'd0) begin
            errors++; $display("FAIL stats: got good=%0d bad=%0d, need 0 1", stat_good_o, stat_bad_o);
        end
`endif
        exp_fcs = 32'hCBF43926;
    endtask

    task automatic test_mid_reset();
        clear_mon(); ready_mode = 0;
        s_valid_i = 1'b1; en_i = 1'b1;
        for (int i = 0; i < 7; i++) begin
            s_data_i = 8'(i + 8'h50); @(posedge clk_i); #1;
        end
        s_valid_i = 1'b0; rstn_i = 1'b0;
        repeat (2) @(posedge clk_i); #1;
        rstn_i = 1'b1;
        clear_mon();
        repeat (4) @(posedge clk_i); #1;
        checks++;
        if (m_valid_o !== 1'b0 || fcs_o !== 32'd0 || n_ok + n_bfcs + n_bframe != 0) begin
            errors++; $display("FAIL mid_reset: got m_valid=%b fcs=%h pulses=%0d, need 0 0 0", m_valid_o, fcs_o, n_ok + n_bfcs + n_bframe);
        end
        exp_fcs = 32'd0;
    endtask

    task automatic test_random_stall();
        bq_t p, f;
        int len, kind, bad;
        logic corrupt;
        ready_mode = 1;
        for (int n = 0; n < 10; n++) begin
            clear_mon();
            len = $urandom_range(2, 24);
            corrupt = ($urandom_range(0, 2) == 0);
            p.delete();
            if (len < 5) begin
                for (int i = 0; i < len; i++) p.push_back(8'($urandom));
                f = p; p.delete(); kind = 2;
            end else begin
                for (int i = 0; i < len - 4; i++) p.push_back(8'($urandom));
                f = with_fcs(p, ref_crc(p) ^ (corrupt ? 32'h00010000 : 32'h0));
                kind = corrupt ? 1 : 0;
                exp_fcs = {f[len-1], f[len-2], f[len-3], f[len-4]};
            end
            send_frame(f, -1, 1'b1, 1'b1, 25);
            drain();
            bad = 0;
            foreach (p[i]) if (i >= q_data.size() || q_data[i] !== p[i] || q_last[i] !== (i == p.size() - 1)) bad++;
            if (kind != 2 && q_user.size() > 0 && q_user[q_user.size() - 1] !== (kind == 1)) bad++;
            checks++;
            if (q_data.size() != p.size() || bad != 0 || stall_err != 0) begin
                errors++; $display("FAIL rand%0d_data: got %0d bytes (%0d wrong, %0d stall) need %0d", n, q_data.size(), bad, stall_err, p.size());
            end
            checks++;
            if (n_ok != int'(kind == 0) || n_bfcs != int'(kind == 1) || n_bframe != int'(kind == 2) || multi_err != 0 || fcs_o !== exp_fcs) begin
                errors++; $display("FAIL rand%0d_result: got ok=%0d fcs=%0d frame=%0d fcs_o=%h, need kind %0d fcs %h", n, n_ok, n_bfcs, n_bframe, fcs_o, kind, exp_fcs);
            end
        end
        ready_mode = 0;
        repeat (2) @(posedge clk_i); #1;
    endtask

    task automatic test_back_to_back();
        bq_t p1, p2, f, exp;
        int bad;
        clear_mon(); ready_mode = 0;
        for (int i = 0; i < 6; i++) p1.push_back(8'($urandom));
        for (int i = 0; i < 3; i++) p2.push_back(8'($urandom));
        f = with_fcs(p1, ref_crc(p1));
        send_frame(f, -1, 1'b1, 1'b1, 0);
        f = with_fcs(p2, ref_crc(p2));
        send_frame(f, -1, 1'b1, 1'b1, 0);
        drain();
        exp = p1;
        foreach (p2[i]) exp.push_back(p2[i]);
        bad = 0;
        foreach (exp[i]) if (i >= q_data.size() || q_data[i] !== exp[i] || q_last[i] !== (i == 5 || i == 8) || q_user[i] !== 1'b0) bad++;
        checks++;
        if (q_data.size() != 9 || bad != 0 || n_ok != 2 || n_bfcs + n_bframe != 0 || fcs_o !== ref_crc(p2)) begin
            errors++; $display("FAIL back_to_back: got %0d bytes (%0d wrong) ok=%0d fcs=%h", q_data.size(), bad, n_ok, fcs_o);
        end
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_good_frame(8'hCB, 32'hCBF43926, 0, "good");
        test_good_frame(8'hCA, 32'hCAF43926, 1, "bad_fcs");
        test_runt();
        test_drop();
        test_user_err();
        test_mid_reset();
        test_random_stall();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/udma_ethernet_rx_fcs.md
Name: udma_ethernet_rx_fcs

Overview:
- Receive-path stage between the MAC byte stream and the uDMA RX channel.
- Computes the Ethernet CRC-32 over each incoming frame, strips the 4-byte FCS and forwards payload bytes downstream.
- Publishes the received FCS and per-frame error pulses; these feed the register interface's rx_fcs and status[3:1] inputs.
- Gated by the en_rx control from the register interface.

Parameters:
- MIN_FRAME, 5, minimum accepted frame length in bytes including FCS; shorter frames are runts. Legal values are 5 and above.

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  asynchronous active-low reset
- en_i  in  1  receive enable, sampled at frame start only
- s_data_i  in  8  input byte from MAC
- s_valid_i  in  1  input byte valid
- s_last_i  in  1  last byte of frame (final FCS byte)
- s_user_i  in  1  PHY/MAC error on this byte
- s_ready_o  out  1  input accepted
- m_data_o  out  8  payload byte
- m_valid_o  out  1  output valid
- m_last_o  out  1  last payload byte
- m_user_o  out  1  frame bad, valid with m_last_o
- m_ready_i  in  1  downstream accept
- fcs_o  out  32  FCS of last completed frame, first received byte in [7:0]
- frame_ok_o  out  1  pulse: good frame
- bad_fcs_o  out  1  pulse: CRC mismatch
- bad_frame_o  out  1  pulse: runt or s_user_i seen

Behaviour:
- Reset values: all outputs 0; crc register 0xFFFFFFFF; state IDLE; fill count 0.
- Handshakes use the valid/ready rule: a transfer occurs when valid and ready are both high.
- m_* is a single registered stage. m_valid_o holds until m_ready_i. m_data_o, m_last_o and m_user_o are stable while stalled.
- s_ready_o = (state==DROP) | (!m_valid_o | m_ready_i). It is combinational and has no dependency on s_valid_i.
- Byte buffer: 4-entry shift buffer buf[0..3], buf[0] oldest.
  - Accepted byte with fill<4: shift in, fill++.
  - Accepted byte with fill==4: evict buf[0] to the m stage, update the CRC with the evicted byte, then shift in.
- CRC: reflected polynomial 0xEDB88320, init 0xFFFFFFFF, one byte per cycle, computed over evicted (payload) bytes only.
- FSM states:
  - IDLE: on the first accepted byte, go to DROP if en_i=0, else go to FILL. A byte with s_last_i on entry is handled per the frame-end rules.
  - FILL: fill<4. s_last_i here is a runt: drop the frame, pulse bad_frame_o, emit no output, go to IDLE.
  - STREAM: fill==4, forward bytes.
  - DROP: consume and discard until s_last_i, raise no pulses, then go to IDLE.
- Frame end (s_last_i accepted in STREAM):
  - rx = {s_data_i, buf[3], buf[2], buf[1]}.
  - calc = ~crc_next(crc, buf[0]).
  - The evicted byte goes out with m_last_o=1 and m_user_o = (calc!=rx) | err_seen.
  - fcs_o <= rx the next cycle.
  - Exactly one pulse the next cycle, in priority order: bad_frame_o (err_seen or byte count < MIN_FRAME), then bad_fcs_o, else frame_ok_o.
  - crc is reset to 0xFFFFFFFF, fill to 0, err_seen cleared, state goes to IDLE.
- err_seen is a sticky flag, set by any accepted byte with s_user_i=1 in FILL or STREAM.
- en_i changes mid-frame are ignored; the current frame completes normally.
- Latency: the first payload byte is valid 1 cycle after the 5th byte is accepted. Throughput is 1 byte/cycle with no bubbles when m_ready_i=1.
- Byte counter is 16 bits and saturates at 0xFFFF.
- Reset mid-frame aborts the frame; no pulses are generated.

Optional Feature:
- Macro: ETH_RX_FCS_STATS_EN.
- When defined, adds:
  - stat_clr_i (in, 1)
  - stat_good_o (out, 16)
  - stat_bad_o (out, 16)
- stat_good_o counts frame_ok_o pulses; stat_bad_o counts bad_fcs_o | bad_frame_o pulses.
- Both counters saturate at 0xFFFF.
- stat_clr_i zeroes both counters. If a clear and an increment occur in the same cycle, the result is 0.
- When undefined, the ports and counters are absent.

Decomposition:
- Package udma_ethernet_pkg holds:
  - ETH_CRC32_POLY = 0xEDB88320
  - ETH_CRC32_INIT = 0xFFFFFFFF
  - the FSM state enum {IDLE, FILL, STREAM, DROP}
  - function crc32_byte(crc, byte)
- Sub-module udma_ethernet_crc32: combinational byte-wide CRC next-state, reused later by the TX FCS generator.

Test Plan:
- Good frame: bytes 0x31..0x39 then 0x26,0x39,0xF4,0xCB, m_ready_i=1 -> 9 bytes out 0x31..0x39, m_last_o on 0x39 with m_user_o=0, fcs_o=0xCBF43926, one frame_ok_o pulse.
- Same frame with last byte 0xCA -> same 9 bytes out, m_user_o=1 on last, bad_fcs_o pulse, fcs_o=0xCAF43926.
- Runt of 3 bytes 0xAA,0xBB,0xCC(last) -> no m_valid_o, bad_frame_o pulse, fcs_o unchanged.
- Good frame with m_ready_i toggling 1-in-3 -> identical output sequence, no byte loss or duplication, m_* stable while stalled.
- en_i=0 at frame start, then en_i=1 mid-frame -> whole frame dropped, no pulses; next frame with en_i=1 passes.
- s_user_i=1 on byte 4 of the good frame -> m_user_o=1 on last, bad_frame_o only; with ETH_RX_FCS_STATS_EN, stat_bad_o=1.
